bcd_convert_scheduler: RTL and testbench

BCD_CONVERT_SCHEDULER -- requirements
Module: bcd_convert_scheduler

---
 rtl/bcd_convert_scheduler_pkg.sv | 35 +++
 rtl/bcd_convert_scheduler_b2bcd.sv | 35 +++
 rtl/bcd_convert_scheduler.sv | 120 ++++++++++++
 tb/tb_bcd_convert_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_convert_scheduler_pkg.sv
//==== bcd_convert_scheduler_pkg -- shared clock constants, FSM states, helpers (rev 1.0) ====
`default_nettype none

package bcd_convert_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CONV = 2'd2
  } state_t;

  localparam logic [1:0] CH_SEC  = 2'd0;
  localparam logic [1:0] CH_MIN  = 2'd1;
  localparam logic [1:0] CH_HOUR = 2'd2;

  localparam logic [5:0] SEC_MIN_MAX      = 6'd59;
  localparam int         HOUR_MAX_DEFAULT = 23;

  // Channel index advanced by step, wrapping modulo the three channels.
  function automatic logic [1:0] ch_wrap(input logic [1:0] ch, input logic [1:0] step);
    logic [2:0] s;
    s = {1'b0, ch} + {1'b0, step};
    if (s >= 3'd3) s = s - 3'd3;
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic out_of_range(input logic [1:0] ch, input logic [5:0] value,
                                        input logic [5:0] hour_limit);
    return (ch == CH_HOUR) ? (value > hour_limit) : (value > SEC_MIN_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_convert_scheduler_b2bcd.sv
//==== binary_to_bcd_no_arith -- 6-bit double-dabble converter, nibble adjust by table (rev 1.0) ====
`default_nettype none

module binary_to_bcd_no_arith (
  input  logic [5:0] bin,
  output logic [7:0] bcd
);

  function automatic logic [3:0] adj(input logic [3:0] n);
    case (n)
      4'd5:    return 4'd8;
      4'd6:    return 4'd9;
      4'd7:    return 4'd10;
      4'd8:    return 4'd11;
      4'd9:    return 4'd12;
      default: return n;
    endcase
  endfunction

  logic [13:0] scratch;

  // Layout: [13:10] tens, [9:6] ones, [5:0] binary being shifted in.
  always_comb begin
    scratch = {8'd0, bin};
    for (int i = 0; i < 6; i++) begin
      scratch[9:6]   = adj(scratch[9:6]);
      scratch[13:10] = adj(scratch[13:10]);
      scratch        = scratch << 1;
    end
    bcd = scratch[13:6];
  end

endmodule

`default_nettype wire

// File: rtl/bcd_convert_scheduler.sv
//==== bcd_convert_scheduler -- round-robin BCD conversion of sec/min/hour counters (rev 1.0) ====
`default_nettype none

module bcd_convert_scheduler
  import bcd_convert_scheduler_pkg::*;
#(
  parameter int HOUR_MAX = HOUR_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [5:0] sec_bin,
  input  logic [5:0] min_bin,
  input  logic [4:0] hour_bin,
  output logic [7:0] bcd_sec,
  output logic [7:0] bcd_min,
  output logic [7:0] bcd_hour,
  output logic [2:0] done,
  output logic [2:0] range_err,
  output logic       busy
);

  localparam logic [5:0] HOUR_LIMIT = 6'(HOUR_MAX);

  state_t     state;
  logic [2:0] pending;
  logic [2:0] pending_next;
  logic [1:0] ptr;
  logic [1:0] grant_ch;
  logic [5:0] operand;
  logic [5:0] operand_next;
  logic [7:0] conv_bcd;
  logic       grant_valid;
  logic [1:0] grant_sel;
  logic [1:0] cand1;
  logic [1:0] cand2;

  binary_to_bcd_no_arith u_b2bcd (
    .bin (operand),
    .bcd (conv_bcd)
  );

  assign cand1 = ch_wrap(ptr, 2'd1);
  assign cand2 = ch_wrap(ptr, 2'd2);

  always_comb begin
    grant_valid = 1'b1;
    grant_sel   = ptr;
    if (pending[ptr])        grant_sel = ptr;
    else if (pending[cand1]) grant_sel = cand1;
    else if (pending[cand2]) grant_sel = cand2;
    else                     grant_valid = 1'b0;
  end

  // A request on the grant edge re-arms the bit it would otherwise clear.
  always_comb begin
    pending_next = pending;
    if (state == ST_IDLE && grant_valid) pending_next = pending & ~(3'b001 << grant_sel);
    pending_next = pending_next | req;
  end

  always_comb begin
    case (grant_ch)
      CH_SEC:  operand_next = sec_bin;
      CH_MIN:  operand_next = min_bin;
      default: operand_next = {1'b0, hour_bin};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pending   <= '0;
      ptr       <= CH_SEC;
      grant_ch  <= CH_SEC;
      operand   <= '0;
      bcd_sec   <= 8'h00;
      bcd_min   <= 8'h00;
      bcd_hour  <= 8'h00;
      done      <= '0;
      range_err <= '0;
      busy      <= 1'b0;
    end else begin
      done    <= '0;
      pending <= pending_next;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            grant_ch <= grant_sel;
            state    <= ST_LOAD;
            busy     <= 1'b1;
          end
        end
        ST_LOAD: begin
          operand <= operand_next;
          state   <= ST_CONV;
        end
        ST_CONV: begin
          case (grant_ch)
            CH_SEC:  bcd_sec  <= conv_bcd;
            CH_MIN:  bcd_min  <= conv_bcd;
            default: bcd_hour <= conv_bcd;
          endcase
          done[grant_ch]      <= 1'b1;
          range_err[grant_ch] <= out_of_range(grant_ch, operand, HOUR_LIMIT);
          ptr                 <= ch_wrap(grant_ch, 2'd1);
          state               <= ST_IDLE;
          busy                <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_convert_scheduler.sv
//==== tb_bcd_convert_scheduler -- directed self-checking bench (rev 1.0) ====
`default_nettype none

module tb_bcd_convert_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic [5:0] sec_bin = 6'd0;
  logic [5:0] min_bin = 6'd0;
  logic [4:0] hour_bin = 5'd0;
  logic [7:0] bcd_sec;
  logic [7:0] bcd_min;
  logic [7:0] bcd_hour;
  logic [2:0] done;
  logic [2:0] range_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  bcd_convert_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .sec_bin   (sec_bin),
    .min_bin   (min_bin),
    .hour_bin  (hour_bin),
    .bcd_sec   (bcd_sec),
    .bcd_min   (bcd_min),
    .bcd_hour  (bcd_hour),
    .done      (done),
    .range_err (range_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 3'b000;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 3'b111;
    tick();
    tick();
    checks++;
    if ({bcd_sec, bcd_min, bcd_hour} !== 24'h000000) begin
      errors++;
      $display("FAIL reset_bcd: got %h want 000000", {bcd_sec, bcd_min, bcd_hour});
    end
    checks++;
    if ({done, range_err, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got done=%b err=%b busy=%b want all 0", done, range_err, busy);
    end
    req   = 3'b000;
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (done !== 3'b000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_discard cyc %0d: got done=%b busy=%b want 000/0", i, done, busy);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    sec_bin = 6'd42;
    req     = 3'b001;
    tick();
    req = 3'b000;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_k: got %b want 0", busy);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (done !== ((i == 3) ? 3'b001 : 3'b000)) begin
        errors++;
        $display("FAIL single_done cyc %0d: got %b want %b", i, done, (i == 3) ? 3'b001 : 3'b000);
      end
      checks++;
      if (busy !== ((i == 1 || i == 2) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL single_busy cyc %0d: got %b", i, busy);
      end
    end
    checks++;
    if (bcd_sec !== 8'h42) begin
      errors++;
      $display("FAIL single_bcd: got %h want 42", bcd_sec);
    end
  endtask

  task automatic test_all_three();
    logic [2:0] exp;
    do_reset();
    sec_bin  = 6'd5;
    min_bin  = 6'd30;
    hour_bin = 5'd23;
    req      = 3'b111;
    tick();
    req = 3'b000;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp = (i == 3) ? 3'b001 : (i == 6) ? 3'b010 : (i == 9) ? 3'b100 : 3'b000;
      checks++;
      if (done !== exp) begin
        errors++;
        $display("FAIL all3_done cyc %0d: got %b want %b", i, done, exp);
      end
    end
    checks++;
    if ({bcd_sec, bcd_min, bcd_hour} !== 24'h053023) begin
      errors++;
      $display("FAIL all3_bcd: got %h want 053023", {bcd_sec, bcd_min, bcd_hour});
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    do_reset();
    sec_bin = 6'd7;
    min_bin = 6'd8;
    req     = 3'b011;
    tick();
    req = 3'b001;
    for (int i = 1; i <= 15; i++) begin
      tick();
      exp = (i == 3 || i == 9 || i == 15) ? 3'b001 : (i == 6 || i == 12) ? 3'b010 : 3'b000;
      checks++;
      if (done !== exp) begin
        errors++;
        $display("FAIL rr_done cyc %0d: got %b want %b", i, done, exp);
      end
      if (i == 8) req = 3'b011;
      if (i == 9) req = 3'b001;
    end
    checks++;
    if (bcd_min !== 8'h08 || bcd_sec !== 8'h07) begin
      errors++;
      $display("FAIL rr_bcd: got min=%h sec=%h want 08/07", bcd_min, bcd_sec);
    end
  endtask

  task automatic test_rerequest();
    logic [2:0] exp;
    do_reset();
    sec_bin = 6'd20;
    req     = 3'b001;
    tick();
    req = 3'b010;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 1) req = 3'b011;
      if (i == 2) req = 3'b000;
      if (i == 3) sec_bin = 6'd21;
      exp = (i == 3) ? 3'b001 : (i == 6) ? 3'b010 : (i == 9) ? 3'b001 : 3'b000;
      checks++;
      if (done !== exp) begin
        errors++;
        $display("FAIL rereq_done cyc %0d: got %b want %b", i, done, exp);
      end
    end
    checks++;
    if (bcd_sec !== 8'h21) begin
      errors++;
      $display("FAIL rereq_bcd: got %h want 21", bcd_sec);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (done !== 3'b000) begin
        errors++;
        $display("FAIL merge_extra cyc %0d: got %b want 000", i, done);
      end
    end
  endtask

  task automatic test_range();
    do_reset();
    sec_bin = 6'd61;
    req     = 3'b001;
    tick();
    req = 3'b000;
    repeat (3) tick();
    checks++;
    if (bcd_sec !== 8'h61 || range_err !== 3'b001) begin
      errors++;
      $display("FAIL range_hi: got bcd=%h err=%b want 61/001", bcd_sec, range_err);
    end
    hour_bin = 5'd24;
    min_bin  = 6'd59;
    req      = 3'b110;
    tick();
    req = 3'b000;
    repeat (6) tick();
    checks++;
    if (bcd_min !== 8'h59 || bcd_hour !== 8'h24 || range_err !== 3'b101) begin
      errors++;
      $display("FAIL range_edges: got min=%h hour=%h err=%b want 59/24/101",
               bcd_min, bcd_hour, range_err);
    end
    sec_bin = 6'd10;
    min_bin = 6'd63;
    req     = 3'b011;
    tick();
    req = 3'b000;
    repeat (6) tick();
    checks++;
    if (bcd_sec !== 8'h10 || bcd_min !== 8'h63 || range_err !== 3'b110) begin
      errors++;
      $display("FAIL range_clear: got sec=%h min=%h err=%b want 10/63/110",
               bcd_sec, bcd_min, range_err);
    end
  endtask

  task automatic test_late_sample();
    do_reset();
    min_bin = 6'd12;
    req     = 3'b010;
    tick();
    req = 3'b000;
    tick();
    min_bin = 6'd13;
    tick();
    tick();
    checks++;
    if (bcd_min !== 8'h13 || done !== 3'b010) begin
      errors++;
      $display("FAIL late_sample: got bcd=%h done=%b want 13/010", bcd_min, done);
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    min_bin = 6'd45;
    req     = 3'b010;
    tick();
    req = 3'b000;
    repeat (3) tick();
    checks++;
    if (bcd_min !== 8'h45) begin
      errors++;
      $display("FAIL abort_setup: got %h want 45", bcd_min);
    end
    sec_bin = 6'd33;
    req     = 3'b001;
    tick();
    req = 3'b000;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (done !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags: got done=%b busy=%b want 000/0", done, busy);
    end
    checks++;
    if ({bcd_sec, bcd_min, bcd_hour} !== 24'h000000) begin
      errors++;
      $display("FAIL abort_bcd: got %h want 000000", {bcd_sec, bcd_min, bcd_hour});
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (done !== 3'b000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_after cyc %0d: got done=%b busy=%b", i, done, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_three();
    test_back_to_back();
    test_rerequest();
    test_range();
    test_late_sample();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
